fifo_ctrl_1r1w: RTL and testbench

//  Pointer/flag controller that turns ram_1r1w_async into a first-word-fall-through FIFO.

---
 rtl/fifo_ctrl_1r1w.sv | 72 +++++++
 tb/tb_fifo_ctrl_1r1w.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_1r1w.sv
// First-word-fall-through FIFO controller for an external 1R1W RAM with an
// async read port. Pointers wrap explicitly so depth_p need not be a power of 2.
module fifo_ctrl_1r1w #(
  parameter  int width_p = 8,
  parameter  int depth_p = 8,
  localparam int aw_lp   = (depth_p > 1) ? $clog2(depth_p) : 1,
  localparam int cw_lp   = $clog2(depth_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i,
  output logic [cw_lp-1:0]   count_o,
  output logic               ram_wr_valid_o,
  output logic [aw_lp-1:0]   ram_wr_addr_o,
  output logic [width_p-1:0] ram_wr_data_o,
  output logic [aw_lp-1:0]   ram_rd_addr_o,
  input  logic [width_p-1:0] ram_rd_data_i
);

  logic [aw_lp-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [cw_lp-1:0] count;
  logic             empty, full, push, pop;

  // Flags come from the occupancy counter so full/empty never alias.
  assign empty = (count == '0);
  assign full  = (count == cw_lp'(depth_p));

  // Handshake flags depend only on state and reset, never on the peer's inputs.
  assign ready_o = ~reset_i & ~full;
  assign valid_o = ~reset_i & ~empty;

  assign push = valid_i & ready_o;
  assign pop  = valid_o & ready_i;

  assign ram_wr_valid_o = push;
  assign ram_wr_addr_o  = wr_ptr;
  assign ram_wr_data_o  = data_i;
  assign ram_rd_addr_o  = rd_ptr;
  assign data_o         = ram_rd_data_i;
  assign count_o        = count;

  always_comb begin
    wr_ptr_nxt = (wr_ptr == aw_lp'(depth_p - 1)) ? '0 : wr_ptr + aw_lp'(1);
    rd_ptr_nxt = (rd_ptr == aw_lp'(depth_p - 1)) ? '0 : rd_ptr + aw_lp'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr_nxt;
      if (pop)  rd_ptr <= rd_ptr_nxt;
      if (push && !pop)      count <= count + cw_lp'(1);
      else if (pop && !push) count <= count - cw_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (count <= cw_lp'(depth_p));
      assert (!(push && full));
    end
  end

endmodule

// File: tb/tb_fifo_ctrl_1r1w.sv
// Scoreboard bench for fifo_ctrl_1r1w: a depth-8 and a depth-5 instance, each
// with a behavioural async-read RAM attached.
module tb_fifo_ctrl_1r1w;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // depth 8 instance
  logic       rst, vin, vout, rin, rdy, wv;
  logic [7:0] din, dout, wd, rd;
  logic [3:0] cnt;
  logic [2:0] wa, ra;
  logic [7:0] mem8 [8];

  fifo_ctrl_1r1w #(.width_p(8), .depth_p(8)) u8 (
    .clk_i(clk), .reset_i(rst), .valid_i(vin), .data_i(din), .ready_o(rdy),
    .valid_o(vout), .data_o(dout), .ready_i(rin), .count_o(cnt),
    .ram_wr_valid_o(wv), .ram_wr_addr_o(wa), .ram_wr_data_o(wd),
    .ram_rd_addr_o(ra), .ram_rd_data_i(rd));

  always_ff @(posedge clk) if (wv) mem8[wa] <= wd;
  assign rd = mem8[ra];

  // depth 5 instance
  logic       rst5, vin5, vout5, rin5, rdy5, wv5;
  logic [7:0] din5, dout5, wd5, rd5;
  logic [2:0] cnt5, wa5, ra5;
  logic [7:0] mem5 [5];

  fifo_ctrl_1r1w #(.width_p(8), .depth_p(5)) u5 (
    .clk_i(clk), .reset_i(rst5), .valid_i(vin5), .data_i(din5), .ready_o(rdy5),
    .valid_o(vout5), .data_o(dout5), .ready_i(rin5), .count_o(cnt5),
    .ram_wr_valid_o(wv5), .ram_wr_addr_o(wa5), .ram_wr_data_o(wd5),
    .ram_rd_addr_o(ra5), .ram_rd_data_i(rd5));

  always_ff @(posedge clk) if (wv5) mem5[wa5] <= wd5;
  assign rd5 = mem5[ra5];

  int         vecs = 0;
  int         errs = 0;
  logic [7:0] q [$];
  logic [7:0] exp_d;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; vin = 1'b1; din = 8'hEE; rin = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vecs++;
      if (rdy !== 1'b0 || vout !== 1'b0 || wv !== 1'b0) begin
        errs++;
        $display("FAIL reset_flags cyc%0d: got rdy=%b vld=%b wv=%b want 0 0 0", i, rdy, vout, wv);
      end
      if (i == 1) begin
        vecs++;
        if (cnt !== 4'd0) begin
          errs++;
          $display("FAIL reset_count: got %0d want 0", cnt);
        end
      end
    end
    next_cycle();
    rst = 1'b0; vin = 1'b0; rin = 1'b0;
    @(negedge clk);
    vecs++;
    if (rdy !== 1'b1 || vout !== 1'b0 || cnt !== 4'd0) begin
      errs++;
      $display("FAIL post_reset: got rdy=%b vld=%b cnt=%0d want 1 0 0", rdy, vout, cnt);
    end
    next_cycle();
  endtask

  task automatic test_fill_drain();
    rin = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vin = 1'b1; din = 8'h10 + 8'(i);
      @(negedge clk);
      vecs++;
      if (rdy !== 1'b1) begin
        errs++;
        $display("FAIL fill_ready push%0d: got %b want 1", i, rdy);
      end
      if (vin && rdy) q.push_back(din);
      next_cycle();
    end
    din = 8'h99;
    @(negedge clk);
    vecs++;
    if (rdy !== 1'b0 || cnt !== 4'd8 || wv !== 1'b0) begin
      errs++;
      $display("FAIL full_state: got rdy=%b cnt=%0d wv=%b want 0 8 0", rdy, cnt, wv);
    end
    next_cycle();
    vin = 1'b0; rin = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(negedge clk);
      if (vout && rin) begin
        exp_d = q.pop_front();
        vecs++;
        if (dout !== exp_d) begin
          errs++;
          $display("FAIL drain_data: got %0h want %0h", dout, exp_d);
        end
      end
      next_cycle();
    end
    vecs++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain_timeout: got %0d left want 0", q.size());
      q.delete();
    end
    @(negedge clk);
    vecs++;
    if (vout !== 1'b0 || cnt !== 4'd0) begin
      errs++;
      $display("FAIL drained_state: got vld=%b cnt=%0d want 0 0", vout, cnt);
    end
    next_cycle();
  endtask

  task automatic test_latency();
    vin = 1'b1; din = 8'hA5; rin = 1'b1;
    @(negedge clk);
    vecs++;
    if (vout !== 1'b0 || rdy !== 1'b1 || wv !== 1'b1) begin
      errs++;
      $display("FAIL empty_push: got vld=%b rdy=%b wv=%b want 0 1 1", vout, rdy, wv);
    end
    if (vin && rdy) q.push_back(din);
    next_cycle();
    vin = 1'b0;
    @(negedge clk);
    vecs++;
    if (vout !== 1'b1) begin
      errs++;
      $display("FAIL latency_valid: got %b want 1", vout);
    end
    if (vout && rin && q.size() != 0) begin
      exp_d = q.pop_front();
      vecs++;
      if (dout !== exp_d) begin
        errs++;
        $display("FAIL latency_data: got %0h want %0h", dout, exp_d);
      end
    end
    next_cycle();
    @(negedge clk);
    vecs++;
    if (vout !== 1'b0 || cnt !== 4'd0) begin
      errs++;
      $display("FAIL latency_after: got vld=%b cnt=%0d want 0 0", vout, cnt);
    end
    q.delete();
    rin = 1'b0;
    next_cycle();
  endtask

  task automatic test_back_to_back();
    rin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vin = 1'b1; din = 8'h20 + 8'(i);
      @(negedge clk);
      if (vin && rdy) q.push_back(din);
      next_cycle();
    end
    rin = 1'b1;
    for (int i = 0; i < 20; i++) begin
      vin = 1'b1; din = 8'h30 + 8'(i);
      @(negedge clk);
      vecs++;
      if (cnt !== 4'd3 || vout !== 1'b1 || rdy !== 1'b1) begin
        errs++;
        $display("FAIL b2b_state cyc%0d: got cnt=%0d vld=%b rdy=%b want 3 1 1", i, cnt, vout, rdy);
      end
      if (vout && rin && q.size() != 0) begin
        exp_d = q.pop_front();
        vecs++;
        if (dout !== exp_d) begin
          errs++;
          $display("FAIL b2b_data cyc%0d: got %0h want %0h", i, dout, exp_d);
        end
      end
      if (vin && rdy) q.push_back(din);
      next_cycle();
    end
    vin = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++) begin
      @(negedge clk);
      if (vout && rin) begin
        exp_d = q.pop_front();
        vecs++;
        if (dout !== exp_d) begin
          errs++;
          $display("FAIL b2b_drain: got %0h want %0h", dout, exp_d);
        end
      end
      next_cycle();
    end
    vecs++;
    if (q.size() != 0 || cnt !== 4'd0) begin
      errs++;
      $display("FAIL b2b_end: got left=%0d cnt=%0d want 0 0", q.size(), cnt);
      q.delete();
    end
    rin = 1'b0;
  endtask

  task automatic test_full_pop_push();
    rin = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vin = 1'b1; din = 8'h40 + 8'(i);
      @(negedge clk);
      if (vin && rdy) q.push_back(din);
      next_cycle();
    end
    din = 8'h48; rin = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vecs++;
      if (rdy !== (i == 1) || cnt !== 4'(8 - i)) begin
        errs++;
        $display("FAIL full_pop cyc%0d: got rdy=%b cnt=%0d want %b %0d", i, rdy, cnt, i == 1, 8 - i);
      end
      if (vout && rin && q.size() != 0) begin
        exp_d = q.pop_front();
        vecs++;
        if (dout !== exp_d) begin
          errs++;
          $display("FAIL full_pop_data: got %0h want %0h", dout, exp_d);
        end
      end
      if (vin && rdy) q.push_back(din);
      next_cycle();
    end
    vin = 1'b0;
    for (int i = 0; i < 12 && q.size() != 0; i++) begin
      @(negedge clk);
      if (vout && rin) begin
        exp_d = q.pop_front();
        vecs++;
        if (dout !== exp_d) begin
          errs++;
          $display("FAIL full_drain: got %0h want %0h", dout, exp_d);
        end
      end
      next_cycle();
    end
    vecs++;
    if (q.size() != 0 || cnt !== 4'd0) begin
      errs++;
      $display("FAIL full_end: got left=%0d cnt=%0d want 0 0", q.size(), cnt);
      q.delete();
    end
    rin = 1'b0;
  endtask

  task automatic test_wrap();
    int wptr = 0;
    int rptr = 0;
    rst5 = 1'b1; vin5 = 1'b0; rin5 = 1'b0; din5 = 8'h00;
    next_cycle();
    rst5 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i < 6) begin vin5 = 1'b1; rin5 = 1'b0; end
      else if (i < 24) begin
        vin5 = ($urandom_range(3) != 0);
        rin5 = ($urandom_range(1) != 0);
      end else begin vin5 = 1'b0; rin5 = 1'b1; end
      din5 = 8'($urandom);
      @(negedge clk);
      vecs++;
      if (cnt5 !== 3'(q.size()) || cnt5 > 3'd5 || rdy5 !== (q.size() != 5) ||
          vout5 !== (q.size() != 0)) begin
        errs++;
        $display("FAIL wrap_state cyc%0d: got cnt=%0d rdy=%b vld=%b want %0d %b %b",
                 i, cnt5, rdy5, vout5, q.size(), q.size() != 5, q.size() != 0);
      end
      vecs++;
      if (ra5 !== 3'(rptr) || (wv5 && wa5 !== 3'(wptr))) begin
        errs++;
        $display("FAIL wrap_ptr cyc%0d: got wa=%0d ra=%0d want %0d %0d", i, wa5, ra5, wptr, rptr);
      end
      if (vout5 && rin5 && q.size() != 0) begin
        exp_d = q.pop_front();
        rptr = (rptr == 4) ? 0 : rptr + 1;
        vecs++;
        if (dout5 !== exp_d) begin
          errs++;
          $display("FAIL wrap_data cyc%0d: got %0h want %0h", i, dout5, exp_d);
        end
      end
      if (vin5 && rdy5 && q.size() < 5) begin
        q.push_back(din5);
        wptr = (wptr == 4) ? 0 : wptr + 1;
      end
      next_cycle();
    end
    vin5 = 1'b0; rin5 = 1'b0;
    q.delete();
  endtask

  task automatic test_reset_mid();
    rin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vin = 1'b1; din = 8'h50 + 8'(i);
      next_cycle();
    end
    vin = 1'b0;
    @(negedge clk);
    vecs++;
    if (cnt !== 4'd4) begin
      errs++;
      $display("FAIL mid_count: got %0d want 4", cnt);
    end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    vecs++;
    if (vout !== 1'b0 || cnt !== 4'd0) begin
      errs++;
      $display("FAIL mid_reset: got vld=%b cnt=%0d want 0 0", vout, cnt);
    end
    vin = 1'b1; din = 8'h3C; rin = 1'b1;
    @(negedge clk);
    if (vin && rdy) q.push_back(din);
    next_cycle();
    vin = 1'b0;
    @(negedge clk);
    vecs++;
    if (vout !== 1'b1 || q.size() != 1) begin
      errs++;
      $display("FAIL mid_push_valid: got vld=%b queued=%0d want 1 1", vout, q.size());
    end else begin
      exp_d = q.pop_front();
      vecs++;
      if (dout !== exp_d) begin
        errs++;
        $display("FAIL mid_push_data: got %0h want %0h", dout, exp_d);
      end
    end
    next_cycle();
    q.delete();
    rin = 1'b0;
  endtask

  initial begin
    rst5 = 1'b1; vin5 = 1'b0; rin5 = 1'b0; din5 = 8'h00;
    test_reset();
    test_fill_drain();
    test_latency();
    test_back_to_back();
    test_full_pop_push();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
